// File: rtl/arb_grant_dispatcher.sv
// rtl/arb_grant_dispatcher.sv - WRR grant consumer: request steering, 2-entry output buffer, order FIFO
// Optional burst-weighted grant cost: define ARB_DISPATCH_BURST_COST_EN.
module arb_grant_dispatcher #(
    parameter int  P_REQUESTER_NUM   = 3,
    parameter int  P_PAYLOAD_W       = 40,
    parameter int  P_LEN_W           = 8,
    parameter int  P_NUM_GRANT_REQ_W = 4,
    parameter int  P_COST_SHIFT      = 2,
    parameter int  P_ORDER_DEPTH     = 4,
    localparam int REQ_NUM_W         = $clog2(P_REQUESTER_NUM)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [P_REQUESTER_NUM-1:0]             m_valid_i,
    input  logic [P_REQUESTER_NUM*P_PAYLOAD_W-1:0] m_payload_i,
    input  logic [P_REQUESTER_NUM*P_LEN_W-1:0]     m_len_i,
    output logic [P_REQUESTER_NUM-1:0]             m_ready_o,
    output logic [P_REQUESTER_NUM-1:0]             arb_req_o,
    input  logic [P_REQUESTER_NUM-1:0]             arb_grant_valid_i,
    output logic [P_NUM_GRANT_REQ_W-1:0]           arb_num_grant_req_o,
    output logic                                   arb_grant_ready_o,
    output logic                                   s_valid_o,
    output logic [P_PAYLOAD_W-1:0]                 s_payload_o,
    output logic [REQ_NUM_W-1:0]                   s_src_idx_o,
    input  logic                                   s_ready_i,
    output logic                                   ord_valid_o,
    output logic [REQ_NUM_W-1:0]                   ord_idx_o,
    input  logic                                   ord_ready_i
);

    localparam int ORD_AW = $clog2(P_ORDER_DEPTH);

    logic                   grant_onehot;
    logic                   grant_any;
    logic [REQ_NUM_W-1:0]   g_idx;
    logic                   g_valid;
    logic [P_PAYLOAD_W-1:0] g_payload;
    logic                   accept;

    logic [P_PAYLOAD_W-1:0] buf_data_q [2];
    logic [REQ_NUM_W-1:0]   buf_idx_q  [2];
    logic                   buf_wr_q, buf_wr_d;
    logic                   buf_rd_q, buf_rd_d;
    logic [1:0]             buf_cnt_q, buf_cnt_d;
    logic                   buf_pop;

    logic [REQ_NUM_W-1:0]   ord_mem_q [P_ORDER_DEPTH];
    logic [ORD_AW:0]        ord_wr_q, ord_wr_d;
    logic [ORD_AW:0]        ord_rd_q, ord_rd_d;
    logic                   ord_full;
    logic                   ord_pop;

    // Lowest set bit wins so the index is always defined, even for illegal grants.
    always_comb begin
        g_idx = '0;
        for (int i = P_REQUESTER_NUM - 1; i >= 0; i--) begin
            if (arb_grant_valid_i[i]) begin
                g_idx = REQ_NUM_W'(i);
            end
        end
    end

    assign grant_onehot = $onehot(arb_grant_valid_i);
    assign grant_any    = |arb_grant_valid_i;
    assign g_valid      = m_valid_i[g_idx];
    assign g_payload    = m_payload_i[g_idx*P_PAYLOAD_W +: P_PAYLOAD_W];

`ifdef ARB_DISPATCH_BURST_COST_EN
    localparam logic [P_LEN_W:0] COST_MAX = (P_LEN_W+1)'((1 << P_NUM_GRANT_REQ_W) - 1);

    logic [P_LEN_W-1:0] g_len;
    logic [P_LEN_W:0]   cost_raw;

    assign g_len    = m_len_i[g_idx*P_LEN_W +: P_LEN_W];
    assign cost_raw = {1'b0, g_len >> P_COST_SHIFT} + (P_LEN_W+1)'(1);

    always_comb begin
        arb_num_grant_req_o = '0;
        if (grant_any) begin
            arb_num_grant_req_o = (cost_raw > COST_MAX) ? P_NUM_GRANT_REQ_W'(COST_MAX)
                                                        : P_NUM_GRANT_REQ_W'(cost_raw);
        end
    end
`else
    logic unused_len;
    assign unused_len          = ^m_len_i;
    assign arb_num_grant_req_o = P_NUM_GRANT_REQ_W'(grant_any);
`endif

    // Space comes from registered counts only, keeping ready off the slave/order pop paths.
    assign ord_full = (ord_wr_q[ORD_AW] != ord_rd_q[ORD_AW]) &&
                      (ord_wr_q[ORD_AW-1:0] == ord_rd_q[ORD_AW-1:0]);
    assign accept   = grant_onehot && g_valid && (buf_cnt_q < 2'd2) && !ord_full && !rst;

    assign arb_req_o         = m_valid_i;
    assign m_ready_o         = accept ? arb_grant_valid_i : '0;
    assign arb_grant_ready_o = accept;

    assign s_valid_o   = (buf_cnt_q != 2'd0);
    assign s_payload_o = buf_data_q[buf_rd_q];
    assign s_src_idx_o = buf_idx_q[buf_rd_q];
    assign buf_pop     = s_valid_o && s_ready_i;

    assign ord_valid_o = (ord_wr_q != ord_rd_q);
    assign ord_idx_o   = ord_mem_q[ord_rd_q[ORD_AW-1:0]];
    assign ord_pop     = ord_valid_o && ord_ready_i;

    always_comb begin
        buf_wr_d  = buf_wr_q ^ accept;
        buf_rd_d  = buf_rd_q ^ buf_pop;
        buf_cnt_d = buf_cnt_q;
        if (accept && !buf_pop) begin
            buf_cnt_d = buf_cnt_q + 2'd1;
        end else if (!accept && buf_pop) begin
            buf_cnt_d = buf_cnt_q - 2'd1;
        end
        ord_wr_d = ord_wr_q + (ORD_AW+1)'(accept);
        ord_rd_d = ord_rd_q + (ORD_AW+1)'(ord_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_cnt_q <= '0;
            buf_wr_q  <= 1'b0;
            buf_rd_q  <= 1'b0;
            ord_wr_q  <= '0;
            ord_rd_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_idx_q[i]  <= '0;
            end
            for (int i = 0; i < P_ORDER_DEPTH; i++) begin
                ord_mem_q[i] <= '0;
            end
        end else begin
            buf_cnt_q <= buf_cnt_d;
            buf_wr_q  <= buf_wr_d;
            buf_rd_q  <= buf_rd_d;
            ord_wr_q  <= ord_wr_d;
            ord_rd_q  <= ord_rd_d;
            if (accept) begin
                buf_data_q[buf_wr_q]                <= g_payload;
                buf_idx_q[buf_wr_q]                 <= g_idx;
                ord_mem_q[ord_wr_q[ORD_AW-1:0]]     <= g_idx;
            end
        end
    end

endmodule

// File: tb/tb_arb_grant_dispatcher.sv
// tb/tb_arb_grant_dispatcher.sv - self-checking bench for arb_grant_dispatcher
module tb_arb_grant_dispatcher;

    localparam int N  = 3;
    localparam int PW = 40;
    localparam int LW = 8;
    localparam int CW = 4;
    localparam int SH = 2;
    localparam int OD = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_valid;
    logic [N*PW-1:0] m_payload;
    logic [N*LW-1:0] m_len;
    logic [N-1:0]    m_ready;
    logic [N-1:0]    arb_req;
    logic [N-1:0]    grant;
    logic [CW-1:0]   cost;
    logic            gready;
    logic            s_valid;
    logic [PW-1:0]   s_payload;
    logic [IW-1:0]   s_idx;
    logic            s_ready;
    logic            ord_valid;
    logic [IW-1:0]   ord_idx;
    logic            ord_ready;

    always #5 clk = ~clk;

    arb_grant_dispatcher dut (
        .clk                 (clk),
        .rst                 (rst),
        .m_valid_i           (m_valid),
        .m_payload_i         (m_payload),
        .m_len_i             (m_len),
        .m_ready_o           (m_ready),
        .arb_req_o           (arb_req),
        .arb_grant_valid_i   (grant),
        .arb_num_grant_req_o (cost),
        .arb_grant_ready_o   (gready),
        .s_valid_o           (s_valid),
        .s_payload_o         (s_payload),
        .s_src_idx_o         (s_idx),
        .s_ready_i           (s_ready),
        .ord_valid_o         (ord_valid),
        .ord_idx_o           (ord_idx),
        .ord_ready_i         (ord_ready)
    );

    int checks   = 0;
    int failures = 0;
    bit do_check = 1'b0;
    logic [N-1:0]  last_mready;
    logic [IW-1:0] last_ord_idx;

    typedef struct packed {
        logic [PW-1:0] pl;
        logic [IW-1:0] idx;
    } ent_t;

    ent_t          bq[$];
    logic [IW-1:0] oq[$];
    bit            fresh = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) begin
            if (g[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [CW-1:0] ref_cost(input logic [N-1:0] g, input logic [N*LW-1:0] len);
        int c;
        if (g == '0) return '0;
        c = int'(len[lowest(g)*LW +: LW]) / (1 << SH) + 1;
        if (c > 15) c = 15;
`ifdef ARB_DISPATCH_BURST_COST_EN
        return CW'(c);
`else
        return (c > 0) ? CW'(1) : CW'(1);
`endif
    endfunction

    // One clock cycle: compare against the queue model, clock, then advance the model.
    task automatic step();
        int          gi;
        bit          acc;
        logic [N-1:0] exp_mr;
        ent_t        e;
        #2;
        gi     = lowest(grant);
        acc    = !rst && $onehot(grant) && m_valid[gi] && (bq.size() < 2) && (oq.size() < OD);
        exp_mr = acc ? grant : '0;
        last_mready  = m_ready;
        last_ord_idx = ord_idx;
        if (do_check) begin
            chk("m_ready", 64'(m_ready), 64'(exp_mr));
            chk("grant_ready", 64'(gready), 64'(acc));
            chk("arb_req", 64'(arb_req), 64'(m_valid));
            chk("s_valid", 64'(s_valid), 64'(bq.size() != 0));
            chk("ord_valid", 64'(ord_valid), 64'(oq.size() != 0));
            if (bq.size() != 0) begin
                chk("s_payload", 64'(s_payload), 64'(bq[0].pl));
                chk("s_src_idx", 64'(s_idx), 64'(bq[0].idx));
            end else if (fresh) begin
                chk("s_payload_rst", 64'(s_payload), 64'(0));
                chk("s_src_idx_rst", 64'(s_idx), 64'(0));
            end
            if (oq.size() != 0) begin
                chk("ord_idx", 64'(ord_idx), 64'(oq[0]));
            end else if (fresh) begin
                chk("ord_idx_rst", 64'(ord_idx), 64'(0));
            end
            if ($onehot0(grant)) begin
                chk("cost", 64'(cost), 64'(ref_cost(grant, m_len)));
            end
        end
        @(posedge clk);
        if (rst) begin
            bq.delete();
            oq.delete();
            fresh = 1'b1;
        end else begin
            if (bq.size() != 0 && s_ready) void'(bq.pop_front());
            if (oq.size() != 0 && ord_ready) void'(oq.pop_front());
            if (acc) begin
                e.pl  = m_payload[gi*PW +: PW];
                e.idx = IW'(gi);
                bq.push_back(e);
                oq.push_back(IW'(gi));
                fresh = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        rst = 1'b0; m_valid = '0; grant = '0; s_ready = 1'b1; ord_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        logic         rst;
        logic [N-1:0] v;
        logic [N-1:0] g;
        logic         sr;
        logic         orr;
        logic [N-1:0] mr;
        logic         gr;
        logic         sv;
        logic         ov;
        logic         chkpl;
    } vec_t;

    vec_t tbl[7];

    logic [127:0]  rnd;
    int            nacc;
    logic [IW-1:0] ord_seq[5];
    logic [CW-1:0] exp7, exp255;

    initial begin
        tbl[0] = '{1'b1, 3'b111, 3'b001, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 3'b010, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 3'b011, 3'b011, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 3'b011, 3'b100, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 3'b000, 3'b000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; m_valid = 3'b111; grant = 3'b001; s_ready = 1'b1; ord_ready = 1'b1;
        m_payload = {40'h33, 40'hA5, 40'h11};
        m_len = '0;
        #1;
        step();
        do_check = 1'b1;

        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst; m_valid = tbl[i].v; grant = tbl[i].g;
            s_ready = tbl[i].sr; ord_ready = tbl[i].orr;
            #2;
            chk("tbl_m_ready", 64'(m_ready), 64'(tbl[i].mr));
            chk("tbl_grant_ready", 64'(gready), 64'(tbl[i].gr));
            chk("tbl_s_valid", 64'(s_valid), 64'(tbl[i].sv));
            chk("tbl_ord_valid", 64'(ord_valid), 64'(tbl[i].ov));
            if (tbl[i].chkpl) begin
                chk("tbl_s_payload", 64'(s_payload), 64'h00_0000_00A5);
                chk("tbl_s_src_idx", 64'(s_idx), 64'(1));
                chk("tbl_ord_idx", 64'(ord_idx), 64'(1));
            end
            step();
        end

        // Output backpressure: two accepts fill the buffer, then release.
        s_ready = 1'b0; ord_ready = 1'b1; m_valid = 3'b001; grant = 3'b001; nacc = 0;
        for (int k = 0; k < 5; k++) begin
            m_payload[0 +: PW] = PW'(40'h100 + k);
            step();
            if (last_mready[0]) nacc++;
        end
        chk("bp_accepts", 64'(nacc), 64'(2));
        chk("bp_blocked", 64'(last_mready), 64'(0));
        s_ready = 1'b1;
        step();
        chk("bp_release_cycle", 64'(last_mready), 64'(0));
        step();
        chk("bp_resume", 64'(last_mready), 64'(3'b001));
        idle(4);

        // Order FIFO full, including a blocked grant during a same-cycle pop.
        s_ready = 1'b1; ord_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            grant = 3'(1 << (k % 3)); m_valid = grant;
            step();
            chk("ofull_accept", 64'(last_mready), 64'(grant));
        end
        grant = 3'b010; m_valid = 3'b010;
        step();
        chk("ofull_block", 64'(last_mready), 64'(0));
        ord_ready = 1'b1;
        step();
        chk("ofull_block_pop", 64'(last_mready), 64'(0));
        ord_seq[0] = last_ord_idx;
        ord_ready = 1'b0;
        step();
        chk("ofull_resume", 64'(last_mready), 64'(3'b010));
        grant = '0; m_valid = '0; ord_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            step();
            ord_seq[k] = last_ord_idx;
        end
        chk("ofull_seq0", 64'(ord_seq[0]), 64'(0));
        chk("ofull_seq1", 64'(ord_seq[1]), 64'(1));
        chk("ofull_seq2", 64'(ord_seq[2]), 64'(2));
        chk("ofull_seq3", 64'(ord_seq[3]), 64'(0));
        chk("ofull_seq4", 64'(ord_seq[4]), 64'(1));
        idle(3);

        // Grant cost.
`ifdef ARB_DISPATCH_BURST_COST_EN
        exp7 = 4'd2; exp255 = 4'd15;
`else
        exp7 = 4'd1; exp255 = 4'd1;
`endif
        grant = 3'b100; m_valid = 3'b100; m_len = {8'd7, 8'd0, 8'd0};
        #1; chk("cost_len7", 64'(cost), 64'(exp7)); step();
        m_len = {8'd255, 8'd0, 8'd0};
        #1; chk("cost_len255", 64'(cost), 64'(exp255)); step();
        grant = '0;
        #1; chk("cost_none", 64'(cost), 64'(0)); step();
        idle(3);

        // Reset mid-operation discards buffered entries.
        s_ready = 1'b0; ord_ready = 1'b0; grant = 3'b001; m_valid = 3'b001;
        step(); step();
        rst = 1'b1;
        step();
        idle(1);
        chk("rst_mid_s_valid", 64'(s_valid), 64'(0));
        chk("rst_mid_ord_valid", 64'(ord_valid), 64'(0));
        idle(2);

        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            case ($urandom_range(0, 3))
                0:       grant = '0;
                1, 2:    grant = 3'(1 << $urandom_range(0, 2));
                default: grant = 3'($urandom);
            endcase
            m_valid = 3'($urandom);
            if ($urandom_range(0, 1) == 1) m_valid = m_valid | grant;
            rnd = {$urandom, $urandom, $urandom, $urandom};
            m_payload = rnd[N*PW-1:0];
            m_len = 24'($urandom);
            s_ready = ($urandom_range(0, 3) != 0);
            ord_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
